// File: rtl/gpio_in4.sv
// Four-port GPIO input block: synchronises and glitch-filters four pin ports,
// exposes filtered values and sticky edge-capture flags with a level interrupt.
module gpio_in4 #(
  parameter int WIDTH = 32,
  parameter int DIV   = 1,
  parameter int EDGE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             wen,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic [WIDTH-1:0] pina,
  input  logic [WIDTH-1:0] pinb,
  input  logic [WIDTH-1:0] pinc,
  input  logic [WIDTH-1:0] pind,
  output logic             irq
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [3:0][WIDTH-1:0] pins;
  logic [3:0][WIDTH-1:0] sync1;
  logic [3:0][WIDTH-1:0] sync2;
  logic [3:0][WIDTH-1:0] samp;
  logic [3:0][WIDTH-1:0] filt;
  logic [3:0][WIDTH-1:0] same;
  logic [3:0][WIDTH-1:0] filtnext;
  logic [3:0][WIDTH-1:0] setbits;
  logic [3:0][WIDTH-1:0] clrbits;
  logic [3:0][WIDTH-1:0] cap;
  logic [CW-1:0]         cnt;
  logic [1:0]            syncvalid;
  logic                  tick;
  logic                  primed;

  assign pins = {pind, pinc, pinb, pina};
  assign tick = (cnt == CW'(DIV - 1));

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      same[p]     = ~(sync2[p] ^ samp[p]);
      filtnext[p] = (filt[p] & ~same[p]) | (sync2[p] & same[p]);
      setbits[p]  = '0;
      if (tick && primed) begin
        if (EDGE != 2) setbits[p] = setbits[p] | (filtnext[p] & ~filt[p]);
        if (EDGE != 1) setbits[p] = setbits[p] | (filt[p] & ~filtnext[p]);
      end
      clrbits[p] = (cs && wen && addr[2] && (addr[1:0] == 2'(p))) ? din : '0;
    end
  end

  // Priming waits until the synchroniser holds a real pin sample, so the
  // first loaded value never looks like an edge from the zeroed reset state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= '0;
      sync2     <= '0;
      samp      <= '0;
      filt      <= '0;
      cap       <= '0;
      cnt       <= '0;
      syncvalid <= '0;
      primed    <= 1'b0;
    end else begin
      sync1     <= pins;
      sync2     <= sync1;
      syncvalid <= {syncvalid[0], 1'b1};
      cnt       <= tick ? '0 : cnt + CW'(1);
      if (tick && syncvalid[1]) begin
        samp <= sync2;
        if (!primed) begin
          filt   <= sync2;
          primed <= 1'b1;
        end else begin
          filt <= filtnext;
        end
      end
      // Set takes priority over a simultaneous clear of the same bit.
      cap <= (cap & ~clrbits) | setbits;
    end
  end

  always_comb begin
    dout = addr[2] ? cap[addr[1:0]] : filt[addr[1:0]];
  end

  assign irq = |cap;

endmodule

// File: tb/tb_gpio_in4.sv
// Scoreboard bench for gpio_in4: four instances cover DIV=1/EDGE=0, DIV=4,
// rising-only and falling-only capture, sharing one bus and one set of pins.
module tb_gpio_in4;

  typedef struct {
    string       tag;
    int          dut;
    int          sel;
    logic [31:0] exp;
  } expect_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs = 1'b0;
  logic        wen = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [31:0] din = '0;
  logic [31:0] pina = '0, pinb = '0, pinc = '0, pind = '0;
  logic [31:0] dout0, dout1, dout2, dout3;
  logic        irq0, irq1, irq2, irq3;

  expect_t sbq[$];
  int      checks = 0;
  int      passed = 0;

  always #50 clk = ~clk;

  gpio_in4 #(.WIDTH(32), .DIV(1), .EDGE(0)) dut0 (
    .clk(clk), .reset(reset), .cs(cs), .wen(wen), .addr(addr), .din(din),
    .dout(dout0), .pina(pina), .pinb(pinb), .pinc(pinc), .pind(pind), .irq(irq0));
  gpio_in4 #(.WIDTH(32), .DIV(4), .EDGE(0)) dut1 (
    .clk(clk), .reset(reset), .cs(cs), .wen(wen), .addr(addr), .din(din),
    .dout(dout1), .pina(pina), .pinb(pinb), .pinc(pinc), .pind(pind), .irq(irq1));
  gpio_in4 #(.WIDTH(32), .DIV(1), .EDGE(1)) dut2 (
    .clk(clk), .reset(reset), .cs(cs), .wen(wen), .addr(addr), .din(din),
    .dout(dout2), .pina(pina), .pinb(pinb), .pinc(pinc), .pind(pind), .irq(irq2));
  gpio_in4 #(.WIDTH(32), .DIV(1), .EDGE(2)) dut3 (
    .clk(clk), .reset(reset), .cs(cs), .wen(wen), .addr(addr), .din(din),
    .dout(dout3), .pina(pina), .pinb(pinb), .pinc(pinc), .pind(pind), .irq(irq3));

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // sel 0..7 reads that register address, sel 8 reads irq
  task automatic pushExpect(input string tag, input int dut, input int sel, input logic [31:0] exp);
    expect_t e;
    e.tag = tag;
    e.dut = dut;
    e.sel = sel;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  // Pops every pending expectation, reads the DUT and compares
  task automatic drainScoreboard();
    expect_t     e;
    logic [31:0] obs;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      addr = e.sel[2:0];
      #1;
      case (e.dut)
        0:       obs = (e.sel == 8) ? {31'b0, irq0} : dout0;
        1:       obs = (e.sel == 8) ? {31'b0, irq1} : dout1;
        2:       obs = (e.sel == 8) ? {31'b0, irq2} : dout2;
        default: obs = (e.sel == 8) ? {31'b0, irq3} : dout3;
      endcase
      checkOutput(e.tag, obs, e.exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic [31:0] d);
    pina = a;
    pinb = b;
    pinc = c;
    pind = d;
  endtask

  task automatic waitClocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [2:0] a, input logic [31:0] d);
    cs   = 1'b1;
    wen  = 1'b1;
    addr = a;
    din  = d;
    waitClocks(1);
    cs   = 1'b0;
    wen  = 1'b0;
  endtask

  task automatic clearAll();
    for (int r = 4; r < 8; r++) busWrite(3'(r), 32'hFFFF_FFFF);
  endtask

  initial begin
    // Held in reset with all pins high: everything reads zero
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitClocks(3);
    for (int r = 0; r < 8; r++) pushExpect($sformatf("rst_reg%0d", r), 0, r, 32'h0);
    pushExpect("rst_irq", 0, 8, 32'h0);
    pushExpect("rst_d1_reg1", 1, 1, 32'h0);
    drainScoreboard();

    reset = 1'b1;
    waitClocks(4);
    pushExpect("prime_a", 0, 0, 32'hFFFF_FFFF);
    pushExpect("prime_capa", 0, 4, 32'h0);
    pushExpect("prime_irq", 0, 8, 32'h0);
    pushExpect("prime_d1_a", 1, 0, 32'hFFFF_FFFF);
    pushExpect("prime_d1_irq", 1, 8, 32'h0);
    drainScoreboard();

    applyStimulus('0, '0, '0, '0);
    waitClocks(12);
    clearAll();
    for (int d = 0; d < 4; d++) pushExpect($sformatf("clrall_irq%0d", d), d, 8, 32'h0);
    drainScoreboard();

    // Basic edge path, DIV=1: filtered value appears on the 4th edge
    applyStimulus(32'h5, '0, '0, '0);
    waitClocks(3);
    pushExpect("lat3_a", 0, 0, 32'h0);
    pushExpect("lat3_capa", 0, 4, 32'h0);
    drainScoreboard();
    waitClocks(1);
    pushExpect("lat4_a", 0, 0, 32'h5);
    pushExpect("lat4_capa", 0, 4, 32'h5);
    pushExpect("lat4_irq", 0, 8, 32'h1);
    drainScoreboard();
    busWrite(3'd4, 32'h1);
    pushExpect("w1c_capa", 0, 4, 32'h4);
    pushExpect("w1c_irq", 0, 8, 32'h1);
    drainScoreboard();
    busWrite(3'd4, 32'h4);
    pushExpect("w1c2_capa", 0, 4, 32'h0);
    pushExpect("w1c2_irq", 0, 8, 32'h0);
    drainScoreboard();
    busWrite(3'd0, 32'hFFFF_FFFF);
    busWrite(3'd2, 32'hFFFF_FFFF);
    pushExpect("ro_a", 0, 0, 32'h5);
    pushExpect("ro_c", 0, 2, 32'h0);
    drainScoreboard();

    // Glitch rejection, DIV=4
    applyStimulus(32'h5, 32'h8, '0, '0);
    waitClocks(1);
    applyStimulus(32'h5, '0, '0, '0);
    waitClocks(12);
    pushExpect("glitch_b", 1, 1, 32'h0);
    pushExpect("glitch_capb", 1, 5, 32'h0);
    drainScoreboard();
    applyStimulus(32'h5, 32'h8, '0, '0);
    waitClocks(12);
    pushExpect("level_b", 1, 1, 32'h8);
    pushExpect("level_capb", 1, 5, 32'h8);
    drainScoreboard();
    applyStimulus(32'h5, '0, '0, '0);
    waitClocks(12);

    // Rising-only vs falling-only capture
    clearAll();
    applyStimulus(32'h5, '0, 32'h1, '0);
    waitClocks(6);
    pushExpect("rise_e1_capc", 2, 6, 32'h1);
    pushExpect("rise_e2_capc", 3, 6, 32'h0);
    drainScoreboard();
    applyStimulus(32'h5, '0, '0, '0);
    waitClocks(6);
    pushExpect("fall_e1_capc", 2, 6, 32'h1);
    pushExpect("fall_e2_capc", 3, 6, 32'h1);
    drainScoreboard();

    // Clear lands on the same edge the capture sets: set wins
    clearAll();
    applyStimulus(32'h5, '0, '0, 32'h1);
    waitClocks(3);
    cs   = 1'b1;
    wen  = 1'b1;
    addr = 3'd7;
    din  = 32'h1;
    waitClocks(1);
    cs   = 1'b0;
    wen  = 1'b0;
    pushExpect("collide_capd", 0, 7, 32'h1);
    pushExpect("collide_irq", 0, 8, 32'h1);
    drainScoreboard();
    busWrite(3'd7, 32'h1);
    pushExpect("clr_capd", 0, 7, 32'h0);
    pushExpect("clr_irq", 0, 8, 32'h0);
    drainScoreboard();

    // Asynchronous reset mid-operation, then priming repeats
    applyStimulus(32'hA5A5_0F0F, '0, '0, 32'h1);
    waitClocks(6);
    #10;
    reset = 1'b0;
    #1;
    pushExpect("midrst_a", 0, 0, 32'h0);
    pushExpect("midrst_d", 0, 3, 32'h0);
    pushExpect("midrst_capa", 0, 4, 32'h0);
    pushExpect("midrst_irq", 0, 8, 32'h0);
    pushExpect("midrst_d1_a", 1, 0, 32'h0);
    drainScoreboard();
    reset = 1'b1;
    waitClocks(4);
    pushExpect("reprime_a", 0, 0, 32'hA5A5_0F0F);
    pushExpect("reprime_d", 0, 3, 32'h1);
    pushExpect("reprime_capd", 0, 7, 32'h0);
    pushExpect("reprime_irq", 0, 8, 32'h0);
    drainScoreboard();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
